// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan driver.
// Frames are packed so digit d sits on bits [7d+6:7d].
package seg_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int SEG_W      = 7;
  localparam logic [6:0] SEG_OFF = 7'b1111111;
  localparam logic [3:0] AN_OFF  = 4'b1111;

  typedef logic [SEG_W-1:0] seg_pattern_t;
  typedef seg_pattern_t [NUM_DIGITS-1:0] frame_t;

  // Active-low one-hot anode select for a digit index.
  function automatic logic [3:0] anode_sel(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/seg_refresh_timer.sv
// Digit-slot timer: prescaler, digit index, dead-time flag and frame-boundary strobe.
module seg_refresh_timer #(
  parameter int REFRESH_DIV = 100000,
  parameter int DEAD_CYCLES = 16
) (
  input  logic       clock,
  input  logic       reset,
  output logic [1:0] idx,
  output logic       dead,
  output logic       boundary
);

  localparam int CW = $clog2(REFRESH_DIV);

  logic [CW-1:0] presc_r;
  logic [1:0]    idx_r;
  logic          tc_s;

  assign tc_s     = (presc_r == CW'(REFRESH_DIV - 1));
  assign idx      = idx_r;
  assign dead     = (presc_r < CW'(DEAD_CYCLES));
  assign boundary = tc_s && (idx_r == 2'd3);

  // Prescaler wraps every slot; digit index advances on the terminal count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      presc_r <= '0;
      idx_r   <= 2'd0;
    end else if (tc_s) begin
      presc_r <= '0;
      idx_r   <= idx_r + 2'd1;
    end else begin
      presc_r <= presc_r + CW'(1);
    end
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Four-digit common-anode scan driver with double-buffered frames and dead time.
// Optional blinking of selected digits is enabled with `define SEG_SCAN_BLINK_EN.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int DEAD_CYCLES = 16
`ifdef SEG_SCAN_BLINK_EN
  , parameter int BLINK_FRAMES = 250
`endif
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        frame_valid,
  output logic        frame_ready,
  input  logic [27:0] frame_data,
  input  logic [3:0]  blank,
`ifdef SEG_SCAN_BLINK_EN
  input  logic [3:0]  blink_mask,
`endif
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        frame_done
);

  logic [1:0] idx_s;
  logic       dead_s;
  logic       boundary_s;
  logic       xfer_s;
  logic [3:0] blank_eff_s;
  logic [3:0] an_nxt_s;
  logic [6:0] seg_nxt_s;

  frame_t     pending_r;
  frame_t     shadow_r;
  logic       pending_full_r;
  logic [3:0] an_r;
  logic [6:0] seg_r;
  logic       frame_done_r;

  seg_refresh_timer #(
    .REFRESH_DIV (REFRESH_DIV),
    .DEAD_CYCLES (DEAD_CYCLES)
  ) u_timer (
    .clock    (clock),
    .reset    (reset),
    .idx      (idx_s),
    .dead     (dead_s),
    .boundary (boundary_s)
  );

  assign frame_ready = !pending_full_r;
  assign xfer_s      = frame_valid && !pending_full_r;

  // Pending/shadow double buffer; the shadow only changes at a frame boundary.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending_r      <= frame_t'({NUM_DIGITS{SEG_OFF}});
      shadow_r       <= frame_t'({NUM_DIGITS{SEG_OFF}});
      pending_full_r <= 1'b0;
    end else if (boundary_s && pending_full_r) begin
      shadow_r       <= pending_r;
      pending_full_r <= 1'b0;
    end else if (xfer_s) begin
      pending_r      <= frame_t'(frame_data);
      pending_full_r <= 1'b1;
    end
  end

`ifdef SEG_SCAN_BLINK_EN
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [BW-1:0] blink_cnt_r;
  logic          blink_phase_r;

  // Frame counter toggles the blink phase every BLINK_FRAMES frames.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      blink_cnt_r   <= '0;
      blink_phase_r <= 1'b0;
    end else if (boundary_s) begin
      if (blink_cnt_r == BW'(BLINK_FRAMES - 1)) begin
        blink_cnt_r   <= '0;
        blink_phase_r <= ~blink_phase_r;
      end else begin
        blink_cnt_r   <= blink_cnt_r + BW'(1);
      end
    end
  end

  assign blank_eff_s = blank | (blink_mask & {4{blink_phase_r}});
`else
  assign blank_eff_s = blank;
`endif

  // Next display value: dark during dead time or when the current digit is blanked.
  always_comb begin
    an_nxt_s  = AN_OFF;
    seg_nxt_s = SEG_OFF;
    if (dead_s || blank_eff_s[idx_s]) begin
      an_nxt_s  = AN_OFF;
      seg_nxt_s = SEG_OFF;
    end else begin
      an_nxt_s  = anode_sel(idx_s);
      seg_nxt_s = shadow_r[idx_s];
    end
  end

  // Output register; frame_done lines up with the last displayed cycle of digit 3.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      an_r         <= AN_OFF;
      seg_r        <= SEG_OFF;
      frame_done_r <= 1'b0;
    end else begin
      an_r         <= an_nxt_s;
      seg_r        <= seg_nxt_s;
      frame_done_r <= boundary_s;
    end
  end

  assign an         = an_r;
  assign seg        = seg_r;
  assign frame_done = frame_done_r;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver (REFRESH_DIV = 8, DEAD_CYCLES = 2) with a cycle model.
module tb_seg_scan_driver;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        frame_valid = 1'b0;
  logic [27:0] frame_data = 28'h0;
  logic [3:0]  blank = 4'b0000;
  logic        frame_ready;
  logic        frame_done;
  logic [3:0]  an;
  logic [6:0]  seg;
`ifdef SEG_SCAN_BLINK_EN
  logic [3:0]  blink_mask = 4'b0000;
`endif

  int ntests = 0;
  int nfail  = 0;

  // Model state: cycle count since reset release, buffers, blink counter.
  int          m;
  logic [27:0] shadow;
  logic [27:0] pend;
  logic        pfull;
  int          bcnt;
  logic        phase;

  // {d3, d2, d1, d0}
  localparam logic [27:0] FA = {7'h4F, 7'h12, 7'h4F, 7'h01};
  localparam logic [27:0] FB = {7'h24, 7'h30, 7'h19, 7'h12};
  localparam logic [27:0] FC = {7'h02, 7'h78, 7'h00, 7'h10};
  localparam logic [27:0] FD = {7'h11, 7'h22, 7'h33, 7'h44};

  always #5 clock = ~clock;

  seg_scan_driver #(
    .REFRESH_DIV (8),
    .DEAD_CYCLES (2)
`ifdef SEG_SCAN_BLINK_EN
    , .BLINK_FRAMES (2)
`endif
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .frame_data  (frame_data),
    .blank       (blank),
`ifdef SEG_SCAN_BLINK_EN
    .blink_mask  (blink_mask),
`endif
    .an          (an),
    .seg         (seg),
    .frame_done  (frame_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h (m=%0d)", tag, obs, exp, m);
    end
  endtask

  task automatic model_reset();
    m      = 0;
    shadow = {28{1'b1}};
    pend   = 28'h0;
    pfull  = 1'b0;
    bcnt   = 0;
    phase  = 1'b0;
  endtask

  // One clock: predict from pre-edge state, advance, then check at the falling edge.
  task automatic tick();
    int p;
    int d;
    logic [3:0] bm;
    logic       blk;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_done;
`ifdef SEG_SCAN_BLINK_EN
    bm = blink_mask;
`else
    bm = 4'b0000;
`endif
    p   = m % 8;
    d   = (m / 8) % 4;
    blk = blank[d] | (phase & bm[d]);
    if (p < 2 || blk) begin
      e_an  = 4'b1111;
      e_seg = 7'h7F;
    end else begin
      e_an    = 4'b1111;
      e_an[d] = 1'b0;
      e_seg   = shadow[d*7 +: 7];
    end
    e_done = (m % 32 == 31);
    if (e_done && pfull) begin
      shadow = pend;
      pfull  = 1'b0;
    end else if (frame_valid && !pfull) begin
      pend  = frame_data;
      pfull = 1'b1;
    end
    if (e_done) begin
      if (bcnt == 1) begin
        bcnt  = 0;
        phase = ~phase;
      end else begin
        bcnt++;
      end
    end
    m++;
    @(posedge clock);
    @(negedge clock);
    chk("an", an, e_an);
    chk("seg", seg, e_seg);
    chk("frame_done", frame_done, e_done);
    chk("frame_ready", frame_ready, !pfull);
    chk("one_anode", $countones(~an) <= 1, 1'b1);
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clock);
    chk("rst_an", an, 4'b1111);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_done", frame_done, 1'b0);
    chk("rst_ready", frame_ready, 1'b1);

    reset = 1'b0;
    tick_n(3);
    chk("idle_d0_an", an, 4'b1110);
    chk("idle_d0_seg", seg, 7'h7F);
    tick_n(29);
    chk("idle_done32", frame_done, 1'b1);
    tick_n(8);

    // Frame A offered mid-scan, shown from the next frame.
    frame_valid = 1'b1;
    frame_data  = FA;
    tick();
    frame_valid = 1'b0;
    chk("a_ready_low", frame_ready, 1'b0);
    tick_n(23);
    chk("a_ready_back", frame_ready, 1'b1);

    // Frame B accepted at once, frame C held until B is swapped in.
    frame_valid = 1'b1;
    frame_data  = FB;
    tick();
    frame_data  = FC;
    tick_n(6);
    chk("a_d0_an", an, 4'b1110);
    chk("a_d0_seg", seg, 7'h01);
    tick_n(25);
    chk("c_ready_after_bnd", frame_ready, 1'b1);
    tick();
    chk("c_accepted", frame_ready, 1'b0);
    frame_valid = 1'b0;
    tick_n(7);
    chk("b_d0_an", an, 4'b1110);
    chk("b_d0_seg", seg, 7'h12);

    // Blank digit 2 mid-frame.
    blank = 4'b0100;
    tick_n(14);
    chk("blank_d2_an", an, 4'b1111);
    chk("blank_d2_seg", seg, 7'h7F);
    tick_n(6);
    chk("blank_d3_an", an, 4'b0111);
    chk("blank_d3_seg", seg, 7'h24);
    tick_n(11);
    chk("c_d0_seg", seg, 7'h10);
    tick_n(13);
    blank = 4'b0000;
    tick();
    chk("unblank_d2_an", an, 4'b1011);
    chk("unblank_d2_seg", seg, 7'h78);

    // Fill pending, then reset during digit 2.
    frame_valid = 1'b1;
    frame_data  = FD;
    tick();
    frame_valid = 1'b0;
    chk("d_pending", frame_ready, 1'b0);
    tick_n(2);
    reset = 1'b1;
    #1;
    chk("mid_rst_an", an, 4'b1111);
    chk("mid_rst_seg", seg, 7'h7F);
    chk("mid_rst_ready", frame_ready, 1'b1);
    chk("mid_rst_done", frame_done, 1'b0);
    model_reset();
    @(negedge clock);
    @(negedge clock);
`ifdef SEG_SCAN_BLINK_EN
    blink_mask = 4'b0001;
`endif
    reset = 1'b0;
    tick_n(3);
    chk("restart_d0_an", an, 4'b1110);
    chk("restart_d0_seg", seg, 7'h7F);
    tick_n(64);
`ifdef SEG_SCAN_BLINK_EN
    chk("blink_dark_f2", an, 4'b1111);
`else
    chk("no_blink_f2", an, 4'b1110);
`endif
    tick_n(64);
    chk("lit_f4", an, 4'b1110);
    chk("discarded_seg", seg, 7'h7F);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
